// File: rtl/round_sat_pipe.sv
// Two-stage multi-channel rounder/saturator with valid/ready flow control.
// Stage 1 rounds each channel (mode captured with the beat); stage 2 saturates and flags clipping.
module round_sat_pipe #(
  parameter int IW   = 24,
  parameter int OW   = 16,
  parameter int DROP = 8,
  parameter int NCH  = 2,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              clr,
  input  logic [NCH*IW-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NCH*OW-1:0] out_data,
  output logic [NCH-1:0]    out_clip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH-1:0]    clip_sticky,
  output logic [CW-1:0]     clip_count
);

  localparam int FW = IW - DROP;      // floor result width
  localparam int RW = IW - DROP + 1;  // one spare bit so the rounding carry cannot wrap
  localparam logic [DROP-1:0] HALF = DROP'(1) << (DROP - 1);

  typedef enum logic [1:0] {
    RM_FLOOR      = 2'd0,
    RM_TRUNC      = 2'd1,
    RM_NEAREST    = 2'd2,
    RM_CONVERGENT = 2'd3
  } rmode_e;

  function automatic logic [RW-1:0] round_one(input logic [IW-1:0] x, input rmode_e m);
    logic [FW-1:0]   fl;
    logic [DROP-1:0] fr;
    logic            inc;
    fl  = x[IW-1:DROP];
    fr  = x[DROP-1:0];
    inc = 1'b0;
    unique case (m)
      RM_FLOOR:      inc = 1'b0;
      RM_TRUNC:      inc = x[IW-1] & (|fr);
      RM_NEAREST:    inc = (fr > HALF) | ((fr == HALF) & ~x[IW-1]);
      RM_CONVERGENT: inc = (fr > HALF) | ((fr == HALF) & fl[0]);
    endcase
    return {fl[FW-1], fl} + RW'(inc);
  endfunction

  // Returns {clip, value}; the value fits when all bits above the output sign agree with it.
  function automatic logic [OW:0] sat_one(input logic [RW-1:0] r);
    logic [RW-OW:0] top;
    top = r[RW-1:OW-1];
    if ((&top) || ~(|top)) return {1'b0, r[OW-1:0]};
    return {1'b1, r[RW-1], {(OW-1){~r[RW-1]}}};
  endfunction

  logic                   s1_valid;
  logic [NCH-1:0][RW-1:0] s1_data;
  logic                   s1_load, s2_load, out_hs;
  logic [NCH-1:0][RW-1:0] rnd;
  logic [NCH*OW-1:0]      sat_data;
  logic [NCH-1:0]         sat_clip;

  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;
  assign out_hs   = out_valid & out_ready;

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    rnd      = '0;
    sat_data = '0;
    sat_clip = '0;
    for (int k = 0; k < NCH; k++) begin
      rnd[k] = round_one(in_data[k*IW +: IW], rmode_e'(mode));
      {sat_clip[k], sat_data[k*OW +: OW]} = sat_one(s1_data[k]);
    end
  end

  // NOTE: datapath registers are reset too, because out_data must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_clip  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= rnd;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat_data;
          out_clip <= sat_clip;
        end
      end
    end
  end

  // Clear has priority over a clipping handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count  <= '0;
      clip_sticky <= '0;
    end else if (clr) begin
      clip_count  <= '0;
      clip_sticky <= '0;
    end else if (out_hs) begin
      clip_sticky <= clip_sticky | out_clip;
      if ((|out_clip) && ~(&clip_count)) clip_count <= clip_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed self-checking bench for round_sat_pipe (IW=8, OW=4, DROP=4, NCH=2, CW=4).
module tb_round_sat_pipe;
  localparam int IW = 8, OW = 4, DROP = 4, NCH = 2, CW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              clr = 1'b0;
  logic [NCH*IW-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NCH*OW-1:0] out_data;
  logic [NCH-1:0]    out_clip;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NCH-1:0]    clip_sticky;
  logic [CW-1:0]     clip_count;

  int n_checks = 0;
  int n_errors = 0;

  round_sat_pipe #(.IW(IW), .OW(OW), .DROP(DROP), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_clip(out_clip), .out_valid(out_valid), .out_ready(out_ready),
    .clip_sticky(clip_sticky), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int floor16(input int a);
    return (a >= 0) ? a / 16 : -((-a + 15) / 16);
  endfunction

  // Reference rounding for DROP=4, OW=4; returns {clip, value[3:0]}.
  function automatic logic [4:0] model(input int v, input int m);
    int fl, fr, r, near;
    fl   = floor16(v);
    fr   = v - fl * 16;
    near = (v >= 0) ? floor16(v + 8) : -floor16(-v + 8);
    case (m)
      0:       r = fl;
      1:       r = v / 16;
      2:       r = near;
      default: r = (fr == 8) ? ((fl % 2 == 0) ? fl : fl + 1) : near;
    endcase
    if (r > 7)  return {1'b1, 4'h7};
    if (r < -8) return {1'b1, 4'h8};
    return {1'b0, 4'(r)};
  endfunction

  // One beat through an otherwise empty pipe; lat counts falling edges after acceptance.
  task automatic xfer(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] m,
                      output logic [7:0] d, output logic [1:0] c, output int lat);
    @(negedge clk);
    in_data = {a1, a0}; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("out_valid_timeout", 32'(out_valid), 32'd1);
    d = out_data;
    c = out_clip;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]        d, a, b;
  logic [1:0]        c, cur_mode;
  logic signed [3:0] r0s;
  logic [4:0]        ma, mb;
  logic [9:0]        e;
  logic [9:0]        exp_q[$];
  logic              acc;
  int lat, prev, sent, recv, cyc;
  int vals[4] = '{24, 40, -24, -40};
  int ex[4][4] = '{'{1, 1, 2, 2}, '{2, 2, 3, 2}, '{-2, -1, -2, -2}, '{-3, -2, -3, -2}};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_clip", 32'(out_clip), 32'd0);
    check("rst_clip_count", 32'(clip_count), 32'd0);
    check("rst_clip_sticky", 32'(clip_sticky), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Rounding modes on the four directed values
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 4; m++) begin
        xfer(8'(vals[i]), 8'(vals[i]), 2'(m), d, c, lat);
        check($sformatf("round_%0d_m%0d", vals[i], m), 32'({c, d}),
              32'({2'b00, 4'(ex[i][m]), 4'(ex[i][m])}));
        check("latency", 32'(lat), 32'd2);
      end
    end

    // Saturation: 127 clips only when rounding carries it past 7; -128 never clips
    xfer(8'd127, 8'h80, 2'd2, d, c, lat);
    check("sat_127_m2", 32'({c, d}), 32'({2'b01, 4'h8, 4'h7}));
    xfer(8'd127, 8'h80, 2'd0, d, c, lat);
    check("sat_127_m0", 32'({c, d}), 32'({2'b00, 4'h8, 4'h7}));
    xfer(8'h80, 8'h80, 2'd1, d, c, lat);
    check("sat_m128_m1", 32'({c, d}), 32'({2'b00, 4'h8, 4'h8}));
    xfer(8'h80, 8'h80, 2'd3, d, c, lat);
    check("sat_m128_m3", 32'({c, d}), 32'({2'b00, 4'h8, 4'h8}));
    settle();
    check("sat_clip_count", 32'(clip_count), 32'd1);
    check("sat_clip_sticky", 32'(clip_sticky), 32'b01);

    // Exhaustive sweep, channel 1 carries the bitwise complement
    for (int m = 0; m < 4; m++) begin
      prev = -100;
      for (int v = -128; v < 128; v++) begin
        a = 8'(v);
        b = ~a;
        xfer(a, b, 2'(m), d, c, lat);
        ma = model(v, m);
        mb = model(int'($signed(b)), m);
        check($sformatf("sweep_m%0d_v%0d", m, v), 32'({c, d}),
              32'({mb[4], ma[4], mb[3:0], ma[3:0]}));
        r0s = d[3:0];
        check("sweep_monotonic", 32'(int'(r0s) >= prev), 32'd1);
        prev = int'(r0s);
      end
    end

    // Plain clear
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_count", 32'(clip_count), 32'd0);
    check("clr_sticky", 32'(clip_sticky), 32'd0);

    // Clear colliding with a clipping handshake
    xfer(8'd127, 8'd0, 2'd2, d, c, lat);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("collide_count", 32'(clip_count), 32'd0);
    check("collide_sticky", 32'(clip_sticky), 32'd0);

    // Counter increments then holds at all-ones
    repeat (3) xfer(8'd127, 8'd0, 2'd2, d, c, lat);
    settle();
    check("count_3", 32'(clip_count), 32'd3);
    repeat (17) xfer(8'd127, 8'd0, 2'd2, d, c, lat);
    settle();
    check("count_sat", 32'(clip_count), 32'd15);
    check("count_sticky", 32'(clip_sticky), 32'b01);

    // Random valid/ready with a mode change every 7 beats
    sent = 0; recv = 0; cyc = 0; cur_mode = 2'd0; in_valid = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
        if (sent % 7 == 0) cur_mode = cur_mode + 2'($urandom_range(1, 3));
        a = 8'($urandom);
        b = 8'($urandom);
        in_data = {b, a};
        mode = cur_mode;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rb_unexpected_beat", 32'(out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rb_beat", 32'({out_clip, out_data}), 32'(e));
        end
        recv++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        ma = model(int'($signed(in_data[7:0])), int'(mode));
        mb = model(int'($signed(in_data[15:8])), int'(mode));
        exp_q.push_back({mb[4], ma[4], mb[3:0], ma[3:0]});
        sent++;
      end
      @(posedge clk);
      #1 if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("rb_recv_count", 32'(recv), 32'd1000);
    check("rb_queue_empty", 32'(exp_q.size()), 32'd0);

    // Async reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; mode = 2'd0; in_data = {8'd24, 8'd24}; in_valid = 1'b1;
    @(negedge clk);
    in_data = {8'd40, 8'd40};
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_full_out_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_clip", 32'(out_clip), 32'd0);
    check("arst_clip_count", 32'(clip_count), 32'd0);
    check("arst_clip_sticky", 32'(clip_sticky), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    xfer(8'd24, 8'd40, 2'd3, d, c, lat);
    check("post_rst_beat", 32'({c, d}), 32'({2'b00, 4'h2, 4'h2}));
    check("post_rst_latency", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/round_sat_pipe.md
# round_sat_pipe

Multi-channel pipelined rounding and saturation stage with run-time rounding mode, valid/ready flow control and clip monitoring. Each beat carries NCH signed samples. Per sample, the block drops DROP LSBs using one of four rounding modes, then saturates to OW bits. It sits between wide DSP datapaths (CIC/halfband outputs, DDC/DUC gain stages) and narrower sample buses. It replaces the fixed-mode combinational rounder wherever registering and backpressure are needed.

## Interface
- IW, 24: input sample width, signed two's complement.
- OW, 16: output sample width; IW-DROP >= OW >= 2.
- DROP, 8: number of LSBs removed; 1 <= DROP <= IW-2.
- NCH, 2: samples per beat; channel k occupies bits [k*W+W-1 : k*W].
- CW, 16: clip counter width.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  rounding mode, sampled with each accepted input beat.
- clr  in  1  synchronous clear of clip counter and sticky flags.
- in_data  in  NCH*IW  packed input samples.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  NCH*OW  packed rounded/saturated samples.
- out_clip  out  NCH  per-channel "this sample saturated" flag, aligned to out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- clip_sticky  out  NCH  per-channel flag, set on any saturated sample, cleared by clr.
- clip_count  out  CW  count of output beats with any out_clip bit set; saturates at all-ones.

## Operation
- Mode 0, floor: arithmetic shift right by DROP.
- Mode 1, toward zero: floor, plus 1 if the input is negative and any dropped bit is nonzero.
- Mode 2, nearest, ties away from zero: add 2^(DROP-1) to positive inputs and 2^(DROP-1)-1 to negative inputs, then floor.
- Mode 3, convergent (ties to even): nearest, except an exact tie goes to the even result.
- Stage 1 computes a rounded value of width IW-DROP+1, so rounding carry cannot wrap. The mode travels with the beat, so a mode change affects only beats accepted after it.
- Stage 2 saturates to the range [-2^(OW-1), 2^(OW-1)-1].
  - out_clip[k]=1 iff channel k was limited.
  - Saturation is symmetric in check but asymmetric in range; -2^(OW-1) is a legal output.
- Channels are independent; there is no cross-channel arithmetic.
- clip_count increments by 1 per output handshake (out_valid & out_ready) with |out_clip. It holds at 2^CW-1.
- clip_sticky[k] sets on an output handshake with out_clip[k]=1.
- When clr and a clipping handshake occur in the same cycle, clr wins: count=0, sticky=0.

## Timing
- Reset (rst_n low, async): out_valid=0, out_data=0, out_clip=0, clip_count=0, clip_sticky=0, internal valids cleared. in_ready=1 from the first edge after rst_n rises.
- Reset mid-stream discards in-flight beats; no partial beat appears after reset.
- Two register stages; latency is 2 cycles from input handshake to out_valid when out_ready=1.
- Full throughput: one beat per cycle with out_ready held high.
- in_ready = !s1_valid | (!s2_valid | out_ready). A stage loads when it is empty or the stage downstream drains in the same cycle.
- Backpressure: while out_ready=0 and both stages are full, in_ready=0. out_data and out_clip hold stable while out_valid=1 and out_ready=0.
- No beat is dropped or duplicated under any valid/ready pattern.
- clip_count and clip_sticky update on the clk edge of the handshake; visible the following cycle.

## Test plan
All directed cases use IW=8, OW=4, DROP=4, NCH=2.
- Rounding modes, in=24 (1.5): modes 0/1/2/3 give 1/1/2/2. In=40 (2.5): 2/2/3/2. In=-24: -2/-1/-2/-2. In=-40: -3/-2/-3/-2. out_clip=0 in all cases.
- Saturation: in=127 in mode 2 gives out=7 with out_clip=1. In mode 0 it gives 7 with out_clip=0. In=-128 in any mode gives -8 with out_clip=0. Afterwards clip_count=1 and clip_sticky reflects only the clipped channel.
- Exhaustive sweep: all 256 inputs × 4 modes, checked against a reference model. Required: zero mismatches and monotonic output.
- Random backpressure: 1000 random beats with random in_valid/out_ready and a mode change every 7 beats. Required: output sequence equals model sequence, with each beat using its own captured mode.
- Clear collision: clr asserted in the same cycle as a clipping handshake gives clip_count=0 and clip_sticky=0 next cycle. Saturation check: CW=4 with 20 clipping beats gives clip_count=15.
- Async reset asserted with 2 beats in flight: all outputs go to 0 immediately, no stale beat appears after release, and the first new beat emerges 2 cycles after acceptance.
